data_cache_ctrl: RTL and testbench

// - Direct-mapped write-back data cache between the CPU and the 32-bit-block data memory.
// - Produces load data that drives the register file WRITEDATA path.
// - Takes store data from register file REGOUT1.
// - Stalls the CPU with BUSYWAIT on a miss while an FSM writes back the dirty line, then refills it.

---
 rtl/data_cache_ctrl_pkg.sv | 35 +++
 rtl/data_cache_ctrl_if.sv | 29 ++
 rtl/dcache_line_store.sv | 57 +++++
 rtl/data_cache_ctrl.sv | 104 ++++++++++
 tb/tb_data_cache_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_cache_ctrl_pkg.sv
// rtl/data_cache_ctrl_pkg.sv - shared widths, FSM encodings and field helpers for the data cache
package data_cache_ctrl_pkg;

    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int ADDR_W      = 8;
    localparam int IDX_W       = $clog2(NUM_BLOCKS);
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
    localparam int MEM_ADDR_W  = TAG_W + IDX_W;
    localparam int LINE_W      = 8 * BLOCK_BYTES;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WB     = 2'd1;
    localparam logic [1:0] ST_FETCH  = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [OFF_W-1:0]  off_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [7:0]        byte_t;

    typedef struct packed {
        tag_t tag;
        idx_t idx;
        off_t off;
    } addr_t;

    // Byte 0 of a line sits in bits [7:0].
    function automatic byte_t line_byte(input line_t line, input off_t off);
        return line[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/data_cache_ctrl_if.sv
// rtl/data_cache_ctrl_if.sv - CPU-side and memory-side signal bundle of the data cache
interface data_cache_ctrl_if;
    import data_cache_ctrl_pkg::*;

    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    byte_t                 writedata;
    byte_t                 readdata;
    logic                  busywait;

    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_address;
    line_t                 mem_writedata;
    line_t                 mem_readdata;
    logic                  mem_busywait;

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/dirty/tag/data arrays with combinational lookup and victim read
module dcache_line_store
    import data_cache_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  idx_t  lookup_idx,
    input  tag_t  lookup_tag,
    input  off_t  lookup_off,
    input  logic  wr_en,
    input  byte_t wr_byte,
    input  logic  fill_en,
    input  idx_t  fill_idx,
    input  tag_t  fill_tag,
    input  line_t fill_data,
    input  idx_t  victim_idx,
    output logic  hit,
    output logic  lookup_dirty,
    output byte_t rd_byte,
    output tag_t  victim_tag,
    output line_t victim_data
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    tag_t                  tag_q  [NUM_BLOCKS];
    line_t                 data_q [NUM_BLOCKS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[lookup_idx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end else if (wr_en) begin
            data_q[lookup_idx][{lookup_off, 3'b000} +: 8] <= wr_byte;
        end
    end

    assign hit          = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign lookup_dirty = dirty_q[lookup_idx];
    assign rd_byte      = line_byte(data_q[lookup_idx], lookup_off);
    assign victim_tag   = tag_q[victim_idx];
    assign victim_data  = data_q[victim_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-back data cache: miss FSM, memory drivers, CPU stall
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    data_cache_ctrl_if.slave bus
);

    addr_t                 req;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [MEM_ADDR_W-1:0] miss_q;
    tag_t                  miss_tag;
    idx_t                  miss_idx;
    byte_t                 readdata_q;

    logic  hit;
    logic  line_dirty;
    logic  miss;
    logic  wr_hit;
    logic  rd_hit;
    byte_t rd_byte;
    tag_t  victim_tag;
    line_t victim_data;

    assign req                  = bus.address;
    assign {miss_tag, miss_idx} = miss_q;

    assign miss   = (bus.read | bus.write) & ~hit;
    assign wr_hit = (state_q == ST_IDLE) & bus.write & hit;
    assign rd_hit = (state_q == ST_IDLE) & bus.read & ~bus.write & hit;

    dcache_line_store u_lines (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (req.idx),
        .lookup_tag   (req.tag),
        .lookup_off   (req.off),
        .wr_en        (wr_hit),
        .wr_byte      (bus.writedata),
        .fill_en      (state_q == ST_UPDATE),
        .fill_idx     (miss_idx),
        .fill_tag     (miss_tag),
        .fill_data    (bus.mem_readdata),
        .victim_idx   (miss_idx),
        .hit          (hit),
        .lookup_dirty (line_dirty),
        .rd_byte      (rd_byte),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (miss) state_d = line_dirty ? ST_WB : ST_FETCH;
            ST_WB:     if (!bus.mem_busywait) state_d = ST_FETCH;
            ST_FETCH:  if (!bus.mem_busywait) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The missing block address is captured so the refill completes even if the CPU drops its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            miss_q     <= '0;
            readdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && miss) begin
                miss_q <= {req.tag, req.idx};
            end
            if (rd_hit) begin
                readdata_q <= rd_byte;
            end
        end
    end

    assign bus.busywait = rst_n & ((state_q != ST_IDLE) | miss);
    assign bus.readdata = rd_hit ? rd_byte : readdata_q;

    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        case (state_q)
            ST_WB: begin
                bus.mem_write     = 1'b1;
                bus.mem_address   = {victim_tag, miss_idx};
                bus.mem_writedata = victim_data;
            end
            ST_FETCH: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = miss_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb/tb_data_cache_ctrl.sv - scoreboard bench for data_cache_ctrl with a latency-modelled memory
module tb_data_cache_ctrl;

    localparam int MEM_LAT = 5;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] mem [64];
    mem_exp_t    exp_mem [$];
    logic [7:0]  exp_rd  [$];

    data_cache_ctrl_if bus ();

    data_cache_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
        exp_mem.push_back({wr, addr, data});
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, output int busy);
        @(negedge clk);
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = d;
        busy          = 0;
        #1;
        while (bus.busywait && busy < 200) begin
            busy++;
            @(negedge clk);
            #1;
        end
        if (busy >= 200) begin
            checks++;
            errors++;
            $display("FAIL access_timeout addr=%h actual=busy expected=ready", a);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    // Memory model: request level sampled each cycle, completes after MEM_LAT busy cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.mem_read || bus.mem_write)) begin
                cnt++;
                if (cnt > MEM_LAT) begin
                    if (bus.mem_write) mem[bus.mem_address] = bus.mem_writedata;
                    else               bus.mem_readdata = mem[bus.mem_address];
                    bus.mem_busywait = 1'b0;
                    cnt = 0;
                end else begin
                    bus.mem_busywait = 1'b1;
                end
            end else begin
                bus.mem_busywait = 1'b1;
                cnt = 0;
            end
        end
    end

    // Monitor: memory transfers and CPU loads completing at the coming edge.
    initial begin
        mem_exp_t e;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            #1;
            if (bus.mem_read || bus.mem_write)
                chk("mem_rw_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (rst_n && !bus.mem_busywait && (bus.mem_read || bus.mem_write)) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected actual=rw%0d addr=%h expected=none",
                             bus.mem_write, bus.mem_address);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_kind", 32'(bus.mem_write), 32'(e.wr));
                    chk("mem_address", 32'(bus.mem_address), 32'(e.addr));
                    if (e.wr) chk("mem_writedata", bus.mem_writedata, e.data);
                end
            end
            if (rst_n && bus.read && !bus.write && !bus.busywait) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=%h expected=none", bus.readdata);
                end else begin
                    r = exp_rd.pop_front();
                    chk("readdata", 32'(bus.readdata), 32'(r));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h01] = 32'h44332211;
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h07] = 32'h88776655;
        mem[6'h0F] = 32'hF3F2F1F0;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
        bus.mem_readdata = '0; bus.mem_busywait = 1'b1;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_readdata",      32'(bus.readdata), 32'd0);
        chk("rst_busywait",      32'(bus.busywait), 32'd0);
        chk("rst_mem_read",      32'(bus.mem_read), 32'd0);
        chk("rst_mem_write",     32'(bus.mem_write), 32'd0);
        chk("rst_mem_address",   32'(bus.mem_address), 32'd0);
        chk("rst_mem_writedata", bus.mem_writedata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold read miss, clean line
        push_mem(1'b0, 6'h01, 32'h0); exp_rd.push_back(8'h22);
        access(1'b1, 1'b0, 8'h05, 8'h00, b); chk("t1_busy_cycles", 32'(b), 32'd8);
        // 2: read hit, zero stall
        exp_rd.push_back(8'h33);
        access(1'b1, 1'b0, 8'h06, 8'h00, b); chk("t2_busy_cycles", 32'(b), 32'd0);
        idle();
        #1 chk("t2_readdata_held", 32'(bus.readdata), 32'h33);

        // 3: write hit, then conflict miss with write-back of the dirty victim
        access(1'b0, 1'b1, 8'h05, 8'h5A, b); chk("t3_write_busy", 32'(b), 32'd0);
        push_mem(1'b1, 6'h01, 32'h44335A11); push_mem(1'b0, 6'h09, 32'h0);
        exp_rd.push_back(8'hBB);
        access(1'b1, 1'b0, 8'h25, 8'h00, b); chk("t3_busy_cycles", 32'(b), 32'd14);

        // 4: write miss on clean line, then dirty eviction proves the store landed
        push_mem(1'b0, 6'h07, 32'h0);
        access(1'b0, 1'b1, 8'h1F, 8'h77, b); chk("t4_busy_cycles", 32'(b), 32'd8);
        exp_rd.push_back(8'h77);
        access(1'b1, 1'b0, 8'h1F, 8'h00, b); chk("t4_hit_busy", 32'(b), 32'd0);
        push_mem(1'b1, 6'h07, 32'h77776655); push_mem(1'b0, 6'h0F, 32'h0);
        exp_rd.push_back(8'hF3);
        access(1'b1, 1'b0, 8'h3F, 8'h00, b); chk("t4_evict_busy", 32'(b), 32'd14);

        // 6: read and write together on a hit: store wins, no memory traffic
        access(1'b1, 1'b1, 8'h3C, 8'h99, b); chk("t6_busy_cycles", 32'(b), 32'd0);
        exp_rd.push_back(8'h99);
        access(1'b1, 1'b0, 8'h3C, 8'h00, b); chk("t6_read_busy", 32'(b), 32'd0);
        exp_rd.push_back(8'hF1);
        access(1'b1, 1'b0, 8'h3D, 8'h00, b); chk("t6_neighbour_busy", 32'(b), 32'd0);

        // 5: reset in the middle of a refill
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h09;
        b = 0;
        do begin
            @(negedge clk);
            #1;
            b++;
        end while (!bus.mem_read && b < 20);
        chk("t5_fetch_started", 32'(bus.mem_read), 32'd1);
        chk("t5_fetch_address", 32'(bus.mem_address), 32'h02);
        rst_n = 1'b0;
        bus.read = 1'b0;
        #1;
        chk("t5_mem_read_drop", 32'(bus.mem_read), 32'd0);
        chk("t5_busywait_drop", 32'(bus.busywait), 32'd0);
        chk("t5_mem_addr_drop", 32'(bus.mem_address), 32'd0);
        chk("t5_readdata_rst",  32'(bus.readdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_mem(1'b0, 6'h01, 32'h0); exp_rd.push_back(8'h5A);
        access(1'b1, 1'b0, 8'h05, 8'h00, b); chk("t5_reread_busy", 32'(b), 32'd8);
        idle();

        repeat (3) @(negedge clk);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        chk("rd_queue_empty",  32'(exp_rd.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
